read_master: RTL
================

Name: read_master

Overview:
- Avalon-MM read initiator for the DMA engine; the source-side counterpart of the DMA write master.
- On a start pulse it fetches a block of 32-bit words from memory starting at a given byte address.
- Each returned word is pushed into the transfer FIFO, which the write master drains.
- Supports pipelined reads (waitrequest plus readdatavalid) with a bounded number of outstanding reads.

Parameters:
MAX_PENDING, 4, maximum outstanding (accepted but not yet returned) reads; range 1..15.

Ports:
iClk  in  1  clock
iReset  in  1  asynchronous active-high reset
iStart  in  1  one-cycle pulse; starts a transfer when idle
iRM_startaddress  in  32  byte start address; word aligned
iLength  in  32  transfer length in bytes; bits [1:0] ignored
iRM_waitrequest  in  1  slave stall; read not accepted while 1
iRM_readdatavalid  in  1  iRM_readdata holds a returned word
iRM_readdata  in  32  read return data
iFF_almostfull  in  1  FIFO free space <= MAX_PENDING words
oRM_read  out  1  Avalon read request
oRM_readaddress  out  32  Avalon read byte address
oFF_writerequest  out  1  FIFO write strobe
oFF_data  out  32  FIFO write data
oRM_busy  out  1  transfer in progress
oRM_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: iReset clears all state asynchronously. Every output is 0 and the state is IDLE. Reset mid-transfer aborts immediately; pending returns are discarded and no done pulse is produced.
- All outputs are registered.
- Internal counters:
  - remaining: 30-bit word count.
  - pending: 4-bit count of outstanding reads.
- States are IDLE, READ, DRAIN, DONE.
- IDLE:
  - iStart=1 latches oRM_readaddress=iRM_startaddress and remaining=iLength[31:2], and sets oRM_busy=1.
  - If remaining is nonzero, go to READ; otherwise go to DONE.
  - iStart in any other state is ignored.
- READ:
  - oRM_read rises when remaining>0, pending<MAX_PENDING and ~iFF_almostfull.
  - Once asserted, oRM_read and oRM_readaddress are held stable while iRM_waitrequest=1, regardless of iFF_almostfull.
  - Accept is oRM_read & ~iRM_waitrequest. On accept: address += 4 (32-bit wrap, no error), remaining -= 1, pending += 1.
  - oRM_read drops in the cycle after an accept unless the issue conditions still hold for the next word. Back-to-back reads at one word per cycle are allowed.
  - When remaining reaches 0, go to DRAIN.
- Returns, in any non-IDLE state:
  - iRM_readdatavalid=1 causes oFF_data<=iRM_readdata and oFF_writerequest<=1 on the next edge, a one-cycle latency. Pending decrements.
  - An accept and a return in the same cycle leave pending unchanged.
  - oFF_writerequest is a single-cycle strobe per return. It never depends on iFF_almostfull.
  - Integrator rule: iFF_almostfull must be asserted when free space <= MAX_PENDING, which guarantees the FIFO never overflows.
- DRAIN: when pending=0 and no return is arriving, go to DONE.
- DONE:
  - oRM_done=1 for exactly one cycle and oRM_busy=0 in that same cycle; return to IDLE.
  - The final FIFO write precedes oRM_done by at least one cycle.
- iRM_readdatavalid in IDLE is ignored.

Optional Feature:
- Macro: RM_PROTOCOL_CHECK_EN.
- With the macro defined:
  - Adds output port oRM_error (1 bit, reset 0).
  - oRM_error sets sticky on iRM_readdatavalid while pending=0.
  - It also sets on pending overflow beyond MAX_PENDING.
  - The offending return is still ignored.
  - It clears only on iReset or on an accepted iStart.
- Without the macro: no port, no logic; stray returns are silently ignored.

Test Plan:
- Basic transfer: start=0x1000, length=16, waitrequest=0, fixed readdatavalid latency 2 -> reads at 0x1000/04/08/0C. There are exactly 4 FIFO writes carrying the returned data in order, then one oRM_done pulse with oRM_busy low.
- Stall: waitrequest held 1 for 3 cycles on the second read -> address stays 0x1004 and oRM_read stays high throughout. Totals: 4 accepts, 4 FIFO writes, done once.
- Pending limit: MAX_PENDING=4, length=40, return latency 10 -> at most 4 accepted reads before the first return. The accept and return counts never differ by more than 4, and all 10 words are written.
- Backpressure: iFF_almostfull=1 before the first read -> no oRM_read issued. Releasing it resumes the reads, and any read already asserted under waitrequest remains asserted.
- Edge lengths: length=0 -> no reads and oRM_done 2 cycles after iStart. length=7 -> exactly 1 read. Start=0xFFFFFFFC, length=8 -> addresses 0xFFFFFFFC then 0x00000000.
- Reset mid-transfer (2 reads pending) -> outputs go 0 asynchronously and there is no done pulse. Late readdatavalid is ignored, or flags oRM_error when RM_PROTOCOL_CHECK_EN is defined. A new iStart then works normally.

Source files
------------

// File: rtl/read_master.sv
// Avalon-MM pipelined read initiator feeding the DMA transfer FIFO.
// Optional protocol checker (oRM_error) enabled by defining RM_PROTOCOL_CHECK_EN.
module read_master #(
    parameter int MAX_PENDING = 4
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iStart,
    input  logic [31:0] iRM_startaddress,
    input  logic [31:0] iLength,
    input  logic        iRM_waitrequest,
    input  logic        iRM_readdatavalid,
    input  logic [31:0] iRM_readdata,
    input  logic        iFF_almostfull,
    output logic        oRM_read,
    output logic [31:0] oRM_readaddress,
    output logic        oFF_writerequest,
    output logic [31:0] oFF_data,
    output logic        oRM_busy,
    output logic        oRM_done
`ifdef RM_PROTOCOL_CHECK_EN
    ,
    output logic        oRM_error
`endif
);

    // state | meaning
    // IDLE  | waiting for iStart
    // READ  | issuing reads until every word has been accepted
    // DRAIN | all reads accepted, waiting for outstanding returns
    // DONE  | one-cycle completion pulse, busy drops
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [4:0] MAX_P = 5'(MAX_PENDING);

    state_t      state;
    logic [29:0] remaining;
    logic [3:0]  pending;

    logic        accept;
    logic        retValid;
    logic [29:0] remainingNext;
    logic [4:0]  pendingNext;
    logic        issueOk;
    logic        unusedLengthBits;

    assign unusedLengthBits = ^iLength[1:0];

    // A return only counts when a read is actually outstanding.
    always_comb begin
        accept        = oRM_read & ~iRM_waitrequest;
        retValid      = iRM_readdatavalid && (pending != 4'd0) && (state != IDLE);
        remainingNext = remaining - {29'd0, accept};
        pendingNext   = {1'b0, pending} + {4'd0, accept} - {4'd0, retValid};
        issueOk       = (remainingNext != 30'd0) && (pendingNext < MAX_P) && !iFF_almostfull;
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state            <= IDLE;
            remaining        <= '0;
            pending          <= '0;
            oRM_read         <= 1'b0;
            oRM_readaddress  <= '0;
            oFF_writerequest <= 1'b0;
            oFF_data         <= '0;
            oRM_busy         <= 1'b0;
            oRM_done         <= 1'b0;
`ifdef RM_PROTOCOL_CHECK_EN
            oRM_error        <= 1'b0;
`endif
        end else begin
            oRM_done         <= 1'b0;
            oFF_writerequest <= retValid;
            if (retValid)
                oFF_data <= iRM_readdata;
            pending <= pendingNext[3:0];

            case (state)
                IDLE: begin
                    oRM_read <= 1'b0;
                    if (iStart) begin
                        oRM_readaddress <= iRM_startaddress;
                        remaining       <= iLength[31:2];
                        oRM_busy        <= 1'b1;
                        state           <= (iLength[31:2] != 30'd0) ? READ : DONE;
`ifdef RM_PROTOCOL_CHECK_EN
                        oRM_error       <= 1'b0;
`endif
                    end
                end
                READ: begin
                    if (accept) begin
                        oRM_readaddress <= oRM_readaddress + 32'd4;
                        remaining       <= remainingNext;
                    end
                    // A stalled request must stay put until the slave takes it.
                    if (!(oRM_read && iRM_waitrequest))
                        oRM_read <= issueOk;
                    if (remainingNext == 30'd0)
                        state <= DRAIN;
                end
                DRAIN: begin
                    oRM_read <= 1'b0;
                    if (pending == 4'd0 && !iRM_readdatavalid)
                        state <= DONE;
                end
                DONE: begin
                    oRM_read <= 1'b0;
                    oRM_done <= 1'b1;
                    oRM_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef RM_PROTOCOL_CHECK_EN
            if ((iRM_readdatavalid && pending == 4'd0) || (pendingNext > MAX_P))
                oRM_error <= 1'b1;
`endif
        end
    end

endmodule
